// File: rtl/conv_weight_sequencer.sv
// rtl/conv_weight_sequencer.sv - kernel weight shadow/active banks with frame-aligned swap and pixel gating
module conv_weight_sequencer #(
    parameter int LineWidthPx = 160,
    parameter int LineCountPx = 120,
    parameter int WidthIn     = 1,
    parameter int KernelWidth = 3,
    parameter int WeightWidth = 2
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      cfg_valid_i,
    output logic                                      cfg_ready_o,
    input  logic [WeightWidth-1:0]                    cfg_data_i,
    input  logic                                      valid_i,
    output logic                                      ready_o,
    input  logic [WidthIn-1:0]                        data_i,
    output logic                                      valid_o,
    input  logic                                      ready_i,
    output logic [WidthIn-1:0]                        data_o,
    output logic [KernelWidth*KernelWidth*WeightWidth-1:0] weights_o,
    output logic                                      swap_o,
    output logic                                      frame_done_o,
    output logic                                      pending_o
);
    localparam int KernelArea = KernelWidth * KernelWidth;
    localparam int BankW      = KernelArea * WeightWidth;
    localparam int CntW       = (KernelArea > 1) ? $clog2(KernelArea) : 1;
    localparam int XW         = (LineWidthPx > 1) ? $clog2(LineWidthPx) : 1;
    localparam int YW         = (LineCountPx > 1) ? $clog2(LineCountPx) : 1;

    localparam logic [0:0] StEmpty = 1'b0;
    localparam logic [0:0] StRun   = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [BankW-1:0] shadow_q, shadow_d;
    logic [BankW-1:0] active_q, active_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic            pending_q, pending_d;
    logic            swap_q, swap_d;
    logic            frame_done_q, frame_done_d;

    logic run, cfg_fire, cfg_last, pix_fire, x_last, y_last;

    assign run      = (state_q == StRun);
    assign cfg_fire = cfg_valid_i & ~pending_q;
    assign cfg_last = (cnt_q == CntW'(KernelArea - 1));
    assign pix_fire = run & valid_i & ready_i;
    assign x_last   = (x_q == XW'(LineWidthPx - 1));
    assign y_last   = (y_q == YW'(LineCountPx - 1));

    // Pixel path is a pure gate: no storage, so RUN adds no bubbles.
    assign cfg_ready_o  = ~pending_q;
    assign ready_o      = run & ready_i;
    assign valid_o      = run & valid_i;
    assign data_o       = data_i;
    assign weights_o    = active_q;
    assign swap_o       = swap_q;
    assign frame_done_o = frame_done_q;
    assign pending_o    = pending_q;

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        cnt_d        = cnt_q;
        x_d          = x_q;
        y_d          = y_q;
        pending_d    = pending_q;
        swap_d       = 1'b0;
        frame_done_d = 1'b0;

        if (cfg_fire) begin
            for (int k = 0; k < KernelArea; k++) begin
                if (cnt_q == CntW'(k)) begin
                    shadow_d[k*WeightWidth +: WeightWidth] = cfg_data_i;
                end
            end
            if (cfg_last) begin
                cnt_d     = '0;
                pending_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end

        // A swap needs pending_q=1, which also blocks cfg_fire, so the
        // pending set/clear above and below never collide.
        case (state_q)
            StEmpty: begin
                if (pending_q) begin
                    active_d  = shadow_q;
                    pending_d = 1'b0;
                    swap_d    = 1'b1;
                    state_d   = StRun;
                end
            end
            StRun: begin
                if (pix_fire) begin
                    if (x_last) begin
                        x_d = '0;
                        y_d = y_last ? '0 : y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                    if (x_last && y_last) begin
                        frame_done_d = 1'b1;
                        if (pending_q) begin
                            active_d  = shadow_q;
                            pending_d = 1'b0;
                            swap_d    = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StEmpty;
            shadow_q     <= '0;
            active_q     <= '0;
            cnt_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            pending_q    <= 1'b0;
            swap_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            pending_q    <= pending_d;
            swap_q       <= swap_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_conv_weight_sequencer.sv
// tb/tb_conv_weight_sequencer.sv - scoreboard bench for conv_weight_sequencer
module tb_conv_weight_sequencer;
    localparam int LW    = 4;
    localparam int LH    = 3;
    localparam int FRAME = LW * LH;
    localparam int KA    = 9;
    localparam int BW    = KA * 2;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          cfg_valid_i = 1'b0;
    logic          cfg_ready_o;
    logic [1:0]    cfg_data_i = '0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [0:0]    data_i = '0;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic [0:0]    data_o;
    logic [BW-1:0] weights_o;
    logic          swap_o;
    logic          frame_done_o;
    logic          pending_o;

    conv_weight_sequencer #(
        .LineWidthPx(LW), .LineCountPx(LH), .WidthIn(1), .KernelWidth(3), .WeightWidth(2)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_data_i(cfg_data_i),
        .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .weights_o(weights_o), .swap_o(swap_o), .frame_done_o(frame_done_o), .pending_o(pending_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          cfg_ready;
        logic          ready;
        logic          valid;
        logic          pending;
        logic          swap;
        logic          fd;
        logic [BW-1:0] w;
        logic          d;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: accepted-pixel position within the frame, shadow word list, active set.
    logic [KA-1:0][1:0] m_shadow, m_active;
    int   m_pix, m_wcnt;
    bit   m_run, m_pending, m_swap, m_fd;

    task automatic model_reset();
        m_shadow = '0; m_active = '0;
        m_pix = 0; m_wcnt = 0;
        m_run = 0; m_pending = 0; m_swap = 0; m_fd = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic cycle(input bit v, input bit r, input logic d, input bit cv,
                         input logic [1:0] cd, output bit fire);
        exp_t e;
        bit cfire;
        @(negedge clk);
        valid_i = v; ready_i = r; data_i = d; cfg_valid_i = cv; cfg_data_i = cd;
        e.cfg_ready = !m_pending;
        e.ready     = m_run && r;
        e.valid     = m_run && v;
        e.pending   = m_pending;
        e.swap      = m_swap;
        e.fd        = m_fd;
        e.w         = m_active;
        e.d         = d;
        exp_q.push_back(e);
        fire  = m_run && v && r;
        cfire = cv && !m_pending;
        m_swap = 0; m_fd = 0;
        if (!m_run) begin
            if (m_pending) begin
                m_active = m_shadow; m_pending = 0; m_swap = 1; m_run = 1;
            end
        end else if (fire) begin
            if (m_pix == FRAME - 1) begin
                m_fd = 1;
                if (m_pending) begin
                    m_active = m_shadow; m_pending = 0; m_swap = 1;
                end
            end
            m_pix = (m_pix + 1) % FRAME;
        end
        if (cfire) begin
            m_shadow[m_wcnt] = cd;
            m_wcnt++;
            if (m_wcnt == KA) begin
                m_wcnt = 0; m_pending = 1;
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_weights"}, 32'(weights_o), 32'(0));
        chk({tag, "_pending"}, 32'(pending_o), 32'(0));
        chk({tag, "_ready_o"}, 32'(ready_o), 32'(0));
        chk({tag, "_valid_o"}, 32'(valid_o), 32'(0));
        chk({tag, "_swap"}, 32'(swap_o), 32'(0));
        chk({tag, "_frame_done"}, 32'(frame_done_o), 32'(0));
        chk({tag, "_cfg_ready"}, 32'(cfg_ready_o), 32'(1));
    endtask

    // Monitor: pops one expected snapshot per driven cycle; pixel data is checked when a pixel is presented.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cfg_ready_o", 32'(cfg_ready_o), 32'(e.cfg_ready));
                chk("ready_o", 32'(ready_o), 32'(e.ready));
                chk("valid_o", 32'(valid_o), 32'(e.valid));
                chk("pending_o", 32'(pending_o), 32'(e.pending));
                chk("swap_o", 32'(swap_o), 32'(e.swap));
                chk("frame_done_o", 32'(frame_done_o), 32'(e.fd));
                chk("weights_o", 32'(weights_o), 32'(e.w));
                if (valid_o === 1'b1 || e.valid)
                    chk("data_o", 32'(data_o), 32'(e.d));
            end
        end
    end

    initial begin : driver
        bit f;
        int acc, n;
        model_reset();
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_i = 1'b0;

        // No config: pixels must stay gated.
        for (int i = 0; i < 20; i++) cycle(1, 1'($urandom), 1'($urandom), 0, 2'b00, f);

        // Back-to-back load of k mod 4, then idle while the swap lands.
        for (int k = 0; k < KA; k++) cycle(0, 1'($urandom), 1'($urandom), 1, 2'(k), f);
        for (int i = 0; i < 6; i++) cycle(0, 1'($urandom), 1'($urandom), 0, 2'b00, f);

        // Full frame with ready toggling.
        acc = 0;
        for (int i = 0; i < 60 && acc < FRAME; i++) begin
            cycle(1, (i % 2 == 0), 1'($urandom), 0, 2'b00, f);
            acc += int'(f);
        end
        chk("s3_pixels_accepted", 32'(acc), 32'(FRAME));
        cycle(0, 0, 0, 0, 2'b00, f);
        cycle(0, 0, 0, 0, 2'b00, f);

        // Mid-frame reload of all-ones, with cfg_valid held past completion.
        acc = 0; n = 0;
        for (int i = 0; i < 80 && acc < FRAME; i++) begin
            bit cv;
            cv = (acc >= 5 && n < 11);
            if (cv) n++;
            cycle(1, (i % 2 == 0), 1'($urandom), cv, 2'b11, f);
            acc += int'(f);
        end
        chk("s4_pixels_accepted", 32'(acc), 32'(FRAME));

        // Last cfg word coincides with the last pixel of a frame; swap deferred one frame.
        for (int i = 0; i < 2 * FRAME; i++)
            cycle(1, 1, 1'($urandom), (i >= FRAME - KA && i < FRAME), 2'($urandom), f);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 2'b00, f);

        // Async reset in the middle of a load and a frame.
        acc = 0;
        for (int i = 0; i < 20 && acc < 7; i++) begin
            cycle(1, 1, 1'($urandom), (i < 4), 2'($urandom), f);
            acc += int'(f);
        end
        chk("s6_pixels_before_reset", 32'(acc), 32'(7));
        cycle(1, 1, 1'($urandom), 0, 2'b00, f);
        #3;
        rst_i = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        for (int i = 0; i < 20; i++) cycle(1, 1, 1'($urandom), 0, 2'b00, f);

        // Fresh load, then random traffic with sporadic reloads.
        for (int k = 0; k < KA; k++) cycle(1'($urandom), 1'($urandom), 1'($urandom), 1, 2'($urandom), f);
        for (int i = 0; i < 500; i++)
            cycle(1'($urandom), 1'($urandom), 1'($urandom), ($urandom % 4 == 0), 2'($urandom), f);

        @(negedge clk);
        valid_i = 0; cfg_valid_i = 0;
        #4;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
